// File: rtl/led_driver_nd_pkg.sv
// Shared constants for the multiplexed seven-segment driver: glyph codes,
// BCD digit type and conversion-width helper.
package led_driver_nd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [SEG_W-1:0] seg_t;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}
  localparam seg_t GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

  // ceil(w * log10(2)) + 1 BCD digits, so a full-scale value never loses a digit
  function automatic int unsigned bcd_digits(input int unsigned w);
    return (w * 30103 + 99999) / 100000 + 1;
  endfunction

endpackage

// File: rtl/led_driver_nd_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
module bin2bcd_seq
  import led_driver_nd_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NBCD   = bcd_digits(DATA_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_bin,
  output logic                  o_busy,
  output logic                  o_done_c,
  output logic [BCD_W*NBCD-1:0] o_bcd_c
);

  localparam int unsigned BCD_TOT = BCD_W * NBCD;
  localparam int unsigned CNT_W   = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]  r_bin;
  logic [BCD_TOT-1:0] r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic [BCD_TOT-1:0] w_adj;
  logic [BCD_TOT-1:0] w_bcd_next;

  // Add 3 to every digit >= 5, then shift in the next binary bit
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < int'(NBCD); i++) begin
      if (r_bcd[BCD_W*i +: BCD_W] >= 4'd5)
        w_adj[BCD_W*i +: BCD_W] = r_bcd[BCD_W*i +: BCD_W] + 4'd3;
    end
    w_bcd_next = {w_adj[BCD_TOT-2:0], r_bin[DATA_W-1]};
  end

  // The last step's result is exposed combinationally so the caller can latch it on the same edge
  assign o_done_c = r_busy && (r_cnt == CNT_W'(1));
  assign o_bcd_c  = w_bcd_next;
  assign o_busy   = r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= CNT_W'(DATA_W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bin <= {r_bin[DATA_W-2:0], 1'b0};
      r_bcd <= w_bcd_next;
      r_cnt <= r_cnt - CNT_W'(1);
      if (o_done_c) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/led_driver_nd.sv
// Multiplexed seven-segment driver: hex or decimal display of a binary value
// with leading-zero blanking, overflow dashes and a registered digit scan.
module led_driver_nd
  import led_driver_nd_pkg::*;
#(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  input  logic              hex_mode,
  input  logic              blank_lz,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [DIGITS-1:0] led_en,
  output logic [7:0]        dest
);

  localparam int unsigned NBCD  = bcd_digits(DATA_W);
  localparam int unsigned EXT   = DIGITS + NBCD;
  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(DIGITS);

  logic                        w_busy;
  logic                        w_conv_done_c;
  logic [BCD_W*NBCD-1:0]       w_bcd_c;
  logic                        w_accept;
  logic                        w_hex_acc;
  logic                        w_update;
  logic [BCD_W*EXT-1:0]        w_src;
  logic                        w_blz;
  logic                        w_ovf;
  logic                        w_nz;
  logic [DIGITS-1:0][SEG_W-1:0] w_glyph_new;
  logic [DIGITS-1:0][SEG_W-1:0] w_disp_next;
  logic                        w_wrap;
  logic [DIV_W-1:0]            w_div_next;
  logic [IDX_W-1:0]            w_idx_next;
  logic [DIGITS-1:0]           w_en_next;
  seg_t                        w_seg_next;

  logic [DIGITS-1:0][SEG_W-1:0] r_disp;
  logic [DIV_W-1:0]            r_div;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_blz;
  logic                        r_done;
  logic                        r_ovf;
  logic [DIGITS-1:0]           r_led_en;
  logic [7:0]                  r_dest;

  assign w_accept  = load && !w_busy;
  assign w_hex_acc = w_accept && hex_mode;
  assign w_update  = w_hex_acc || w_conv_done_c;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .NBCD   (NBCD)
  ) u_bin2bcd (
    .clk      (clk),
    .reset    (reset),
    .i_start  (load && !hex_mode),
    .i_bin    (data),
    .o_busy   (w_busy),
    .o_done_c (w_conv_done_c),
    .o_bcd_c  (w_bcd_c)
  );

  // New display contents: hex nibbles on a hex accept, else the finishing BCD result
  always_comb begin
    w_src = w_hex_acc ? (BCD_W*EXT)'(data) : (BCD_W*EXT)'(w_bcd_c);
    w_blz = w_hex_acc ? blank_lz : r_blz;
    w_ovf = !w_hex_acc && (|w_src[BCD_W*EXT-1:BCD_W*DIGITS]);
    w_nz  = 1'b0;
    w_glyph_new = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      w_nz = w_nz || (w_src[BCD_W*i +: BCD_W] != 4'd0);
      if (w_ovf)
        w_glyph_new[i] = SEG_DASH;
      else if (w_blz && !w_nz && (i != 0))
        w_glyph_new[i] = SEG_BLANK;
      else
        w_glyph_new[i] = GLYPH[w_src[BCD_W*i +: BCD_W]];
    end
  end

  // Scan outputs are driven from next-state so led_en and dest switch together
  always_comb begin
    w_disp_next = w_update ? w_glyph_new : r_disp;
    w_wrap      = (r_div == DIV_W'(SCAN_DIV - 1));
    w_div_next  = w_wrap ? '0 : r_div + DIV_W'(1);
    w_idx_next  = r_idx;
    if (w_wrap)
      w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    w_en_next  = DIGITS'(1) << w_idx_next;
    w_seg_next = w_disp_next[w_idx_next];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp   <= '0;
      r_div    <= '0;
      r_idx    <= '0;
      r_blz    <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_led_en <= ACTIVE_LOW ? ~DIGITS'(1) : DIGITS'(1);
      r_dest   <= ACTIVE_LOW ? 8'hFF : 8'h00;
    end else begin
      r_disp   <= w_disp_next;
      r_div    <= w_div_next;
      r_idx    <= w_idx_next;
      r_done   <= w_update;
      if (w_update) r_ovf <= w_ovf;
      if (w_accept) r_blz <= blank_lz;
      r_led_en <= ACTIVE_LOW ? ~w_en_next : w_en_next;
      r_dest   <= ACTIVE_LOW ? ~{1'b0, w_seg_next} : {1'b0, w_seg_next};
    end
  end

  assign busy     = w_busy;
  assign done     = r_done;
  assign overflow = r_ovf;
  assign led_en   = r_led_en;
  assign dest     = r_dest;

endmodule

// File: tb/tb_led_driver_nd.sv
// Self-checking bench for led_driver_nd with DIGITS=4, DATA_W=16, SCAN_DIV=4, active-low outputs.
module tb_led_driver_nd;

  logic        clk;
  logic        reset;
  logic [15:0] data;
  logic        load;
  logic        hex_mode;
  logic        blank_lz;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [3:0]  led_en;
  logic [7:0]  dest;

  int asserts  = 0;
  int failures = 0;

  led_driver_nd #(
    .DIGITS     (4),
    .DATA_W     (16),
    .SCAN_DIV   (4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .load     (load),
    .hex_mode (hex_mode),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .led_en   (led_en),
    .dest     (dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hex;
    logic        blz;
    logic [15:0] val;
    logic [31:0] exp;   // {digit3, digit2, digit1, digit0} as seen on dest
    logic        ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Load held across exactly one rising edge; returns at the negedge of the following cycle
  task automatic apply_load(input logic hx, input logic blz, input logic [15:0] v);
    @(negedge clk);
    data = v; hex_mode = hx; blank_lz = blz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic read_digit(input int k, output logic [7:0] g);
    logic [3:0] want;
    want = ~(4'b0001 << k);
    g = 8'hxx;
    for (int n = 0; n < 40; n++) begin
      if (led_en === want) begin
        g = dest;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_digits(input string name, input logic [31:0] exp);
    logic [7:0] g;
    for (int k = 0; k < 4; k++) begin
      read_digit(k, g);
      check($sformatf("%s digit%0d", name, k), 32'(g), 32'(exp[8*k +: 8]));
    end
  endtask

  // Decimal conversion timing; kind 1 injects a second load at T+5, kind 2 a reset at T+8
  task automatic dec_timing(input string name, input logic [15:0] v, input int kind);
    logic eb, ed;
    apply_load(1'b0, 1'b0, v);
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) @(negedge clk);
      eb = (kind == 2 && k > 8) ? 1'b0 : (k <= 16);
      ed = !(kind == 2 && k > 8) && (k == 17);
      check($sformatf("%s busy T+%0d", name, k), 32'(busy), 32'(eb));
      check($sformatf("%s done T+%0d", name, k), 32'(done), 32'(ed));
      if (k == 17) check($sformatf("%s overflow", name), 32'(overflow), 32'(0));
      if (kind == 1 && k == 5) begin data = 16'd777; load = 1'b1; end
      if (kind == 1 && k == 6) load = 1'b0;
      if (kind == 2 && k == 8) reset = 1'b1;
      if (kind == 2 && k == 9) reset = 1'b0;
    end
  endtask

  initial begin
    bit ok;

    vecs[0]  = '{1'b0, 1'b0, 16'd1234,  32'hF9A4B099, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'd42,    32'hFFFF99A4, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'd0,     32'hFFFFFFC0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 16'd54321, 32'hBFBFBFBF, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 16'hBEEF,  32'h8386868E, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'd9999,  32'h90909090, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'd10000, 32'hBFBFBFBF, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 16'h00A5,  32'hFFFF8892, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'd42,    32'hC0C099A4, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000,  32'hC0C0C0C0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 16'd905,   32'hFF90C092, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 16'h0000,  32'hFFFFFFC0, 1'b0};

    reset = 1'b1; load = 1'b0; data = '0; hex_mode = 1'b0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and scan order
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset overflow", 32'(overflow), 32'(0));
    check("reset led_en", 32'(led_en), 32'(4'b1110));
    check("reset dest", 32'(dest), 32'(8'hFF));
    for (int c = 1; c <= 16; c++) begin
      logic [3:0] want;
      @(negedge clk);
      want = ~(4'b0001 << ((c / 4) % 4));
      check($sformatf("scan led_en c=%0d", c), 32'(led_en), 32'(want));
      check($sformatf("scan dest c=%0d", c), 32'(dest), 32'(8'hFF));
    end

    dec_timing("dec1234", 16'd1234, 0);
    check_digits("dec1234", 32'hF9A4B099);

    dec_timing("ignored", 16'd4321, 1);
    check_digits("ignored", 32'h99B0A4F9);

    for (int i = 0; i < 12; i++) begin
      apply_load(vecs[i].hex, vecs[i].blz, vecs[i].val);
      wait_done(ok);
      check($sformatf("vec%0d done seen", i), 32'(ok), 32'(1));
      check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      check($sformatf("vec%0d busy at done", i), 32'(busy), 32'(0));
      check_digits($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Set overflow first, then abort a conversion with reset
    apply_load(1'b0, 1'b0, 16'd54321);
    wait_done(ok);
    check("pre-abort overflow", 32'(overflow), 32'(1));
    dec_timing("abort", 16'd1234, 2);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check($sformatf("abort no done %0d", n), 32'(done), 32'(0));
    end
    check("abort busy", 32'(busy), 32'(0));
    check("abort overflow", 32'(overflow), 32'(0));
    check_digits("abort blank", 32'hFFFFFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
